// File: rtl/cy_arb4_rr.sv
// cy_arb4_rr: four-way round-robin arbiter with optional tenure cap.
// Drives a registered one-hot grant and the matching 4:1 mux select.
module cy_arb4_rr #(
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       switch
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  localparam logic [7:0] HOLD = 8'(MAX_HOLD);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic [3:0] cand;
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;
  logic       hit;
  logic [1:0] pick;
  logic [3:0] pick_oh;
  logic       own;
  logic       expired;

  // The current owner never competes in its own handover.
  assign cand = req & ~grant;

  // Rotate candidates so the priority pointer lands on bit 0,
  // then take the first set bit.
  always_comb begin
    dbl = {cand, cand} >> ptr;
    rot = dbl[3:0];
    off = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign hit     = |cand;
  assign pick    = ptr + off;
  assign pick_oh = 4'b0001 << pick;
  assign own     = req[sel];

  // An uncapped arbiter never forces a handover.
  generate
    if (MAX_HOLD == 0) begin : g_unl
      assign expired = 1'b0;
    end else begin : g_cap
      assign expired = (cnt >= HOLD);
    end
  endgenerate

  // Arbitration FSM; every output is a register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      grant  <= 4'b0000;
      sel    <= 2'b00;
      busy   <= 1'b0;
      switch <= 1'b0;
      ptr    <= 2'b00;
      cnt    <= 8'd0;
    end else begin
      switch <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            grant  <= pick_oh;
            sel    <= pick;
            busy   <= 1'b1;
            switch <= 1'b1;
            cnt    <= 8'd1;
            ptr    <= pick + 2'd1;
            state  <= OWNED;
          end
        end
        OWNED: begin
          if (own && !expired) begin
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          end else if (hit) begin
            grant  <= pick_oh;
            sel    <= pick;
            switch <= 1'b1;
            cnt    <= 8'd1;
            ptr    <= pick + 2'd1;
          end else if (own) begin
            cnt <= HOLD;
          end else begin
            grant <= 4'b0000;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot: assert property (
    @(posedge clock) disable iff (!reset_n) $onehot0(grant));
  a_busy: assert property (
    @(posedge clock) disable iff (!reset_n) busy == |grant);
  a_sel: assert property (
    @(posedge clock) disable iff (!reset_n)
      busy |-> grant[sel]);

endmodule

// File: tb/tb_cy_arb4_rr.sv
// tb_cy_arb4_rr: directed vectors for both the uncapped and
// MAX_HOLD=3 builds, checked through an expected-response queue.
module tb_cy_arb4_rr;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req0, req3;
  logic [3:0] g0, g3;
  logic [1:0] s0, s3;
  logic       b0, b3, sw0, sw3;

  cy_arb4_rr #(.MAX_HOLD(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req0),
    .grant(g0), .sel(s0), .busy(b0), .switch(sw0)
  );

  cy_arb4_rr #(.MAX_HOLD(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req(req3),
    .grant(g3), .sel(s3), .busy(b3), .switch(sw3)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned id;
    int unsigned n;
    logic [3:0]  g;
    logic [1:0]  s;
    logic        b;
    logic        sw;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned n_step = 0;

  task automatic chk(
    input string       nm,
    input int unsigned n,
    input logic [3:0]  ag,
    input logic [1:0]  as,
    input logic        ab,
    input logic        asw,
    input logic [3:0]  eg,
    input logic [1:0]  es,
    input logic        eb,
    input logic        esw
  );
    n_chk++;
    if (ag === eg && as === es && ab === eb && asw === esw)
      n_pass++;
    else
      $display("FAIL %s#%0d: got grant=%b sel=%b busy=%b switch=%b, want grant=%b sel=%b busy=%b switch=%b",
               nm, n, ag, as, ab, asw, eg, es, eb, esw);
  endtask

  // Drive one request vector and queue the response due after the next edge.
  task automatic step(
    input int unsigned id,
    input logic [3:0]  r,
    input logic [3:0]  eg,
    input logic [1:0]  es,
    input logic        eb,
    input logic        esw
  );
    exp_t e;
    @(negedge clock);
    if (id == 0) req0 = r;
    else         req3 = r;
    n_step++;
    e.id = id; e.n = n_step;
    e.g = eg; e.s = es; e.b = eb; e.sw = esw;
    q.push_back(e);
  endtask

  // Monitor: compare the registered outputs just after each edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        if (mon_e.id == 0)
          chk("dut0", mon_e.n, g0, s0, b0, sw0,
              mon_e.g, mon_e.s, mon_e.b, mon_e.sw);
        else
          chk("dut3", mon_e.n, g3, s3, b3, sw3,
              mon_e.g, mon_e.s, mon_e.b, mon_e.sw);
      end
    end
  end

  initial begin
    int waited;
    reset_n = 1'b0;
    req0 = 4'b1111;
    req3 = 4'b1111;
    repeat (3) @(posedge clock);
    #1;
    chk("rst0", 0, g0, s0, b0, sw0, 4'b0000, 2'b00, 1'b0, 1'b0);
    chk("rst3", 0, g3, s3, b3, sw3, 4'b0000, 2'b00, 1'b0, 1'b0);
    #1;
    req0 = 4'b0000;
    req3 = 4'b0000;
    reset_n = 1'b1;
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // single requester, then release; sel holds
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // ptr=3: owner 2 drops while 0 and 3 rise
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

    // fairness: each owner drops after one cycle
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(0, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(0, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b1);
    step(0, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b1);
    step(0, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // uncapped build keeps the owner under competition
    step(0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      step(0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // tenure cap of 3 with two contenders
    for (int t = 0; t < 3; t++) begin
      step(1, 4'b0011, (t == 1) ? 4'b0010 : 4'b0001,
           (t == 1) ? 2'd1 : 2'd0, 1'b1, 1'b1);
      step(1, 4'b0011, (t == 1) ? 4'b0010 : 4'b0001,
           (t == 1) ? 2'd1 : 2'd0, 1'b1, 1'b0);
      step(1, 4'b0011, (t == 1) ? 4'b0010 : 4'b0001,
           (t == 1) ? 2'd1 : 2'd0, 1'b1, 1'b0);
      if (t == 2) break;
    end
    // lone owner past the cap keeps the grant
    for (int i = 0; i < 5; i++)
      step(1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    // asynchronous reset in the middle of a tenure
    step(0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst", 0, g0, s0, b0, sw0, 4'b0000, 2'b00, 1'b0, 1'b0);
    req0 = 4'b1111;
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
